ldpc_dvb_enc_mux_pp: RTL and testbench

- Parametrised successor to the encoder data/parity output muxer.
- Merges systematic data columns and parity-accumulator rows into a 1..4-bank output buffer, with the same 1-cycle write path.
- Adds bank rotation, a reader-release handshake, back-pressure, parity-length checking and error reporting.
- Sits between the encoder engine and the output buffer/reader.

---
 rtl/ldpc_dvb_enc_mux_pp_pkg.sv | 22 ++
 rtl/ldpc_dvb_enc_bank_ctrl.sv | 48 ++++
 rtl/ldpc_dvb_enc_mux_pp.sv | 110 +++++++++++
 tb/tb_ldpc_dvb_enc_mux_pp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_dvb_enc_mux_pp_pkg.sv
// Shared encoder output types: column/data/bank words, parity frame strobes and bank stepping.
package ldpc_dvb_enc_mux_pp_pkg;

  localparam int unsigned cZW       = 360;
  localparam int unsigned cCOL_W    = 8;
  localparam int unsigned cBANK_W   = 2;

  typedef logic [cCOL_W-1:0]  col_t;
  typedef logic [cZW-1:0]     zdat_t;
  typedef logic [cBANK_W-1:0] bank_t;

  // Bank-free parity frame markers, qualified by the parity valid
  typedef struct packed {
    logic sof;
    logic eof;
  } pstrb_t;

  function automatic int unsigned bank_inc(input int unsigned bank, input int unsigned num);
    return (bank + 1 >= num) ? 0 : bank + 1;
  endfunction

endpackage

// File: rtl/ldpc_dvb_enc_bank_ctrl.sv
// Output buffer bank rotation: write/read pointers, per-bank full flags and reader release.
module ldpc_dvb_enc_bank_ctrl
  import ldpc_dvb_enc_mux_pp_pkg::*;
#(
  parameter int unsigned pBANK_NUM = 2,
  parameter int unsigned pBANK_W   = 1
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               ieof,
  input  logic               irelease,
  output logic [pBANK_W-1:0] owbank,
  output logic               obusy_c,
  output logic               orel_err_c
);

  localparam int unsigned cSLOTS = 1 << pBANK_W;

  logic [cSLOTS-1:0]  busy;
  logic [cSLOTS-1:0]  busy_nxt;
  logic [pBANK_W-1:0] rbank;
  logic               rel_ok;

  assign obusy_c    = busy[owbank];
  assign rel_ok     = irelease & busy[rbank];
  assign orel_err_c = irelease & ~busy[rbank];

  // Release clears before eof sets, so a shared bank ends up full
  always_comb begin
    busy_nxt = busy;
    if (rel_ok) busy_nxt[rbank] = 1'b0;
    if (ieof)   busy_nxt[owbank] = 1'b1;
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      busy   <= '0;
      owbank <= '0;
      rbank  <= '0;
    end else if (iclkena) begin
      busy <= busy_nxt;
      if (ieof)   owbank <= pBANK_W'(bank_inc(32'(owbank), pBANK_NUM));
      if (rel_ok) rbank  <= pBANK_W'(bank_inc(32'(rbank), pBANK_NUM));
    end
  end

endmodule

// File: rtl/ldpc_dvb_enc_mux_pp.sv
// Encoder output muxer: merges data columns and parity rows into a rotating multi-bank buffer.
module ldpc_dvb_enc_mux_pp
  import ldpc_dvb_enc_mux_pp_pkg::*;
#(
  parameter int unsigned pZW       = 360,
  parameter int unsigned pCOL_W    = 8,
  parameter int unsigned pBANK_NUM = 2,
  parameter int unsigned pBANK_W   = 1
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic [pCOL_W-1:0]  iused_data_col,
  input  logic [pCOL_W-1:0]  iused_par_col,
  input  logic               ival,
  input  logic [pCOL_W-1:0]  icol,
  input  logic [pZW-1:0]     idat,
  input  logic               ipval,
  input  logic               ipsof,
  input  logic               ipeof,
  input  logic [pZW-1:0]     ipacc,
  input  logic [pZW-1:0]     ipline,
  input  logic               irelease,
  output logic               owrite,
  output logic [pBANK_W-1:0] owbank,
  output logic [pCOL_W-1:0]  owaddr,
  output logic [pZW-1:0]     owdat,
  output logic               opwrite,
  output logic [pCOL_W-1:0]  opwaddr,
  output logic               owfull,
  output logic               obusy,
  output logic               oerr
);

  logic               busy_c;
  logic               rel_err_c;
  logic [pBANK_W-1:0] wbank;
  pstrb_t             strb_c;
  logic               try_c;
  logic               accept_c;
  logic               eof_acc_c;
  logic               len_err_c;
  logic [pCOL_W-1:0]  pidx_c;
  logic [pCOL_W-1:0]  pcnt;

  ldpc_dvb_enc_bank_ctrl #(
    .pBANK_NUM (pBANK_NUM),
    .pBANK_W   (pBANK_W)
  ) u_bank_ctrl (
    .iclk       (iclk),
    .ireset     (ireset),
    .iclkena    (iclkena),
    .ieof       (eof_acc_c),
    .irelease   (irelease),
    .owbank     (wbank),
    .obusy_c    (busy_c),
    .orel_err_c (rel_err_c)
  );

  assign obusy = busy_c;

  // Accept decode and frame-length check on the completing parity word
  always_comb begin
    strb_c     = '{sof: ipval & ipsof, eof: ipval & ipeof};
    try_c      = ival | ipval;
    accept_c   = try_c & ~busy_c;
    eof_acc_c  = accept_c & strb_c.eof;
    pidx_c     = strb_c.sof ? '0 : pCOL_W'(pcnt + pCOL_W'(1));
    len_err_c  = pidx_c != pCOL_W'(iused_par_col - pCOL_W'(1));
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      owrite  <= 1'b0;
      opwrite <= 1'b0;
      owfull  <= 1'b0;
      oerr    <= 1'b0;
      owbank  <= '0;
      pcnt    <= '0;
    end else if (iclkena) begin
      owrite  <= accept_c;
      opwrite <= accept_c & ipval;
      owfull  <= eof_acc_c;
      oerr    <= (try_c & busy_c) | rel_err_c | (eof_acc_c & len_err_c);
      if (accept_c) owbank <= wbank;
      if (accept_c & ipval) pcnt <= strb_c.sof ? '0 : pCOL_W'(pcnt + pCOL_W'(1));
    end
  end

  // Write payload is not reset; parity words chain from the previous written word
  always_ff @(posedge iclk) begin
    if (iclkena && accept_c) begin
      if (ipval) begin
        if (strb_c.sof) begin
          owaddr  <= iused_data_col;
          owdat   <= ipacc ^ ipline;
          opwaddr <= '0;
        end else begin
          owaddr  <= pCOL_W'(owaddr + pCOL_W'(1));
          owdat   <= ipacc ^ owdat;
          opwaddr <= pCOL_W'(opwaddr + pCOL_W'(1));
        end
      end else begin
        owaddr <= icol;
        owdat  <= idat;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_dvb_enc_mux_pp.sv
// Bench: two muxers (2 banks and 1 bank) on shared stimulus, checked against a frame/bank-count model.
module tb_ldpc_dvb_enc_mux_pp;

  localparam int unsigned ZW = 360;
  localparam int unsigned CW = 8;

  logic          iclk = 1'b0;
  logic          ireset;
  logic          iclkena;
  logic [CW-1:0] iused_data_col, iused_par_col, icol;
  logic          ival, ipval, ipsof, ipeof, irelease;
  logic [ZW-1:0] idat, ipacc, ipline;

  logic          w_write [2];
  logic [0:0]    w_bank  [2];
  logic [CW-1:0] w_addr  [2];
  logic [ZW-1:0] w_dat   [2];
  logic          w_pwrite[2];
  logic [CW-1:0] w_paddr [2];
  logic          w_full  [2];
  logic          w_busy  [2];
  logic          w_err   [2];

  int nvec = 0;
  int nerr = 0;

  always #5 iclk = ~iclk;

  ldpc_dvb_enc_mux_pp #(.pZW(ZW), .pCOL_W(CW), .pBANK_NUM(2), .pBANK_W(1)) dut2 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iused_data_col(iused_data_col), .iused_par_col(iused_par_col),
    .ival(ival), .icol(icol), .idat(idat), .ipval(ipval), .ipsof(ipsof), .ipeof(ipeof),
    .ipacc(ipacc), .ipline(ipline), .irelease(irelease),
    .owrite(w_write[0]), .owbank(w_bank[0]), .owaddr(w_addr[0]), .owdat(w_dat[0]),
    .opwrite(w_pwrite[0]), .opwaddr(w_paddr[0]), .owfull(w_full[0]), .obusy(w_busy[0]),
    .oerr(w_err[0])
  );

  ldpc_dvb_enc_mux_pp #(.pZW(ZW), .pCOL_W(CW), .pBANK_NUM(1), .pBANK_W(1)) dut1 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iused_data_col(iused_data_col), .iused_par_col(iused_par_col),
    .ival(ival), .icol(icol), .idat(idat), .ipval(ipval), .ipsof(ipsof), .ipeof(ipeof),
    .ipacc(ipacc), .ipline(ipline), .irelease(irelease),
    .owrite(w_write[1]), .owbank(w_bank[1]), .owaddr(w_addr[1]), .owdat(w_dat[1]),
    .opwrite(w_pwrite[1]), .opwaddr(w_paddr[1]), .owfull(w_full[1]), .obusy(w_busy[1]),
    .oerr(w_err[1])
  );

  // Model: a bank count plus the write pointer; the write bank is full only when every bank is
  int            nb[2] = '{2, 1};
  int            fcnt[2], wb[2];
  logic          ew[2], ep[2], ef[2], ee[2];
  logic [0:0]    eb[2];
  logic [CW-1:0] ea[2], epa[2], pc[2];
  logic [ZW-1:0] ed[2];
  bit            ad_known[2] = '{0, 0};
  bit            pa_known[2] = '{0, 0};

  function automatic logic [ZW-1:0] rnd_z();
    logic [383:0] t;
    for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
    return t[ZW-1:0];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      fcnt[m] = 0; wb[m] = 0; pc[m] = '0; eb[m] = '0;
      ew[m] = 0; ep[m] = 0; ef[m] = 0; ee[m] = 0;
    end
  endtask

  task automatic model_step();
    bit busy, try_w, acc, rel_ok, eof_a;
    int idx;
    if (ireset) begin model_reset(); return; end
    if (!iclkena) return;
    for (int m = 0; m < 2; m++) begin
      busy   = (fcnt[m] == nb[m]);
      try_w  = ival | ipval;
      acc    = try_w && !busy;
      rel_ok = irelease && (fcnt[m] > 0);
      eof_a  = acc && ipval && ipeof;
      idx    = ipsof ? 0 : ((int'(pc[m]) + 1) % 256);
      ee[m]  = (try_w && busy) || (irelease && !rel_ok) ||
               (eof_a && idx != ((int'(iused_par_col) + 255) % 256));
      ew[m]  = acc;
      ep[m]  = acc && ipval;
      ef[m]  = eof_a;
      if (acc) begin
        eb[m] = 1'(wb[m]);
        if (ipval && ipsof) begin
          ea[m] = iused_data_col; ed[m] = ipacc ^ ipline; epa[m] = '0; pc[m] = '0;
          ad_known[m] = 1; pa_known[m] = 1;
        end else if (ipval) begin
          ea[m] = ea[m] + 8'd1; ed[m] = ipacc ^ ed[m]; epa[m] = epa[m] + 8'd1; pc[m] = pc[m] + 8'd1;
        end else begin
          ea[m] = icol; ed[m] = idat; ad_known[m] = 1;
        end
      end
      if (rel_ok) fcnt[m]--;
      if (eof_a) begin fcnt[m]++; wb[m] = (wb[m] + 1) % nb[m]; end
    end
  endtask

  task automatic chk(input string tag, input int m, input logic [ZW-1:0] obs, input logic [ZW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, m, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk("owrite", m, ZW'(w_write[m]), ZW'(ew[m]));
      chk("opwrite", m, ZW'(w_pwrite[m]), ZW'(ep[m]));
      chk("owfull", m, ZW'(w_full[m]), ZW'(ef[m]));
      chk("oerr", m, ZW'(w_err[m]), ZW'(ee[m]));
      chk("obusy", m, ZW'(w_busy[m]), ZW'(fcnt[m] == nb[m]));
      chk("owbank", m, ZW'(w_bank[m]), ZW'(eb[m]));
      if (ad_known[m]) begin
        chk("owaddr", m, ZW'(w_addr[m]), ZW'(ea[m]));
        chk("owdat", m, w_dat[m], ed[m]);
      end
      if (pa_known[m]) chk("opwaddr", m, ZW'(w_paddr[m]), ZW'(epa[m]));
    end
  endtask

  task automatic idle();
    iclkena = 1; ival = 0; ipval = 0; ipsof = 0; ipeof = 0; irelease = 0;
    icol = '0; idat = '0; ipacc = '0; ipline = '0;
  endtask

  task automatic tick();
    @(posedge iclk);
    model_step();
    @(negedge iclk);
    check_all();
    idle();
  endtask

  task automatic data(input logic [CW-1:0] c);
    ival = 1; icol = c; idat = rnd_z(); tick();
  endtask

  task automatic par(input bit sof, input bit eof, input logic [ZW-1:0] acc, input logic [ZW-1:0] line);
    ipval = 1; ipsof = sof; ipeof = eof; ipacc = acc; ipline = line; tick();
  endtask

  task automatic rel();
    irelease = 1; tick();
  endtask

  logic [ZW-1:0] a_w, b_w, l_w;

  initial begin
    ireset = 1; idle();
    iused_data_col = 8'd3; iused_par_col = 8'd2;
    model_reset();
    repeat (2) @(negedge iclk);
    check_all();
    ireset = 0;

    // Three data columns then a two-word parity frame
    a_w = rnd_z(); b_w = rnd_z(); l_w = rnd_z();
    data(8'd0); data(8'd1); data(8'd2);
    chk("addr_d2", 0, ZW'(w_addr[0]), ZW'(8'd2));
    par(1, 0, a_w, l_w);
    chk("addr_sof", 0, ZW'(w_addr[0]), ZW'(8'd3));
    chk("dat_sof", 0, w_dat[0], a_w ^ l_w);
    chk("paddr_sof", 0, ZW'(w_paddr[0]), ZW'(8'd0));
    par(0, 1, b_w, l_w);
    chk("addr_eof", 0, ZW'(w_addr[0]), ZW'(8'd4));
    chk("dat_eof", 0, w_dat[0], b_w ^ a_w ^ l_w);
    chk("paddr_eof", 0, ZW'(w_paddr[0]), ZW'(8'd1));
    chk("full_eof", 0, ZW'(w_full[0]), ZW'(1'b1));
    chk("bank_eof", 0, ZW'(w_bank[0]), ZW'(1'b0));
    chk("err_eof", 0, ZW'(w_err[0]), ZW'(1'b0));

    // Second frame fills bank 1; further writes are dropped until a release
    iused_par_col = 8'd1;
    par(1, 1, rnd_z(), rnd_z());
    chk("busy_2full", 0, ZW'(w_busy[0]), ZW'(1'b1));
    data(8'd9);
    chk("drop_write", 0, ZW'(w_write[0]), ZW'(1'b0));
    chk("drop_err", 0, ZW'(w_err[0]), ZW'(1'b1));
    rel();
    chk("busy_rel", 0, ZW'(w_busy[0]), ZW'(1'b0));
    data(8'd9);
    chk("write_b0", 0, ZW'(w_write[0]), ZW'(1'b1));
    chk("bank_b0", 0, ZW'(w_bank[0]), ZW'(1'b0));
    rel(); rel(); rel();

    // Short frame against an expected length of four
    iused_par_col = 8'd4;
    par(1, 0, rnd_z(), rnd_z()); par(0, 0, rnd_z(), rnd_z()); par(0, 1, rnd_z(), rnd_z());
    chk("short_full", 0, ZW'(w_full[0]), ZW'(1'b1));
    chk("short_err", 0, ZW'(w_err[0]), ZW'(1'b1));
    rel(); rel();

    // Single-bank eof and release together leaves the bank full
    iused_par_col = 8'd1;
    ipval = 1; ipsof = 1; ipeof = 1; ipacc = rnd_z(); ipline = rnd_z(); irelease = 1; tick();
    chk("nb1_busy", 1, ZW'(w_busy[1]), ZW'(1'b1));
    rel(); rel();

    // Data and parity together take the parity path
    iused_data_col = 8'd77;
    ival = 1; icol = 8'd5; idat = rnd_z(); ipval = 1; ipsof = 1; ipacc = rnd_z(); ipline = rnd_z(); tick();
    chk("both_addr", 0, ZW'(w_addr[0]), ZW'(8'd77));
    chk("both_pw", 0, ZW'(w_pwrite[0]), ZW'(1'b1));

    // Asynchronous reset in the middle of a parity frame
    par(0, 0, rnd_z(), rnd_z());
    ipval = 1; ipacc = rnd_z();
    #2 ireset = 1;
    #1 model_reset();
    check_all();
    @(negedge iclk); ireset = 0; idle();

    // Clock enable held low mid-frame with live inputs
    par(1, 0, rnd_z(), rnd_z());
    for (int i = 0; i < 5; i++) begin
      ipval = 1; ipeof = 1; ival = 1; irelease = 1; ipacc = rnd_z(); iclkena = 0;
      tick();
    end
    par(0, 0, rnd_z(), rnd_z());

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 32) == 0) iused_data_col = 8'($urandom);
      if (($urandom % 32) == 0) iused_par_col = 8'($urandom_range(1, 6));
      iclkena  = ($urandom % 10) != 0;
      ival     = ($urandom % 3) == 0;
      icol     = 8'($urandom);
      idat     = rnd_z();
      ipval    = ($urandom % 2) == 0;
      ipsof    = ($urandom % 4) == 0;
      ipeof    = ($urandom % 4) == 0;
      ipacc    = rnd_z();
      ipline   = rnd_z();
      irelease = ($urandom % 5) == 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
